// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

   typedef enum logic [2:0] {StLen, StData, StChk, StDone, StErr} state_e;

   localparam int unsigned LEN_BYTES = 4;
   localparam int unsigned BYTE_W    = 8;

endpackage

// File: rtl/word_assembler.sv
// Collects four stream bytes into a little-endian 32-bit word; flags the byte that completes it.
module word_assembler
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              byte_en,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [1:0]        byte_idx,
   output logic              word_valid,
   output logic [31:0]       word
);

   logic [1:0]  idx_q;
   logic [31:0] fill_q;

   // word already includes the byte being accepted, so the 4th byte yields the full word
   always_comb begin
      word = fill_q;
      word[BYTE_W*idx_q +: BYTE_W] = byte_in;
      word_valid = byte_en && (idx_q == 2'(LEN_BYTES - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         fill_q <= '0;
      end else if (clear) begin
         idx_q  <= '0;
         fill_q <= '0;
      end else if (byte_en) begin
         idx_q  <= idx_q + 2'd1;
         fill_q <= word;
      end
   end

   assign byte_idx = idx_q;

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: length header, LE data words, XOR checksum; holds core in reset.
module imem_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_rst_n,
   output logic              load_done,
   output logic              load_err
);

   localparam int unsigned TW       = $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [31:0]   LEN_MAX  = 32'd1 << ADDR_W;

   state_e              state_q, state_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic [7:0]          csum_q, csum_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic                mem_we_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [31:0]         wdata_d;
   logic                accept, timing_on, asm_clear, asm_en, word_valid;
   logic [1:0]          byte_idx;
   logic [31:0]         asm_word;

   assign accept = rx_valid && rx_ready;
   assign asm_en = accept && (state_q == StLen || state_q == StData);

   word_assembler u_asm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (asm_clear),
      .byte_en    (asm_en),
      .byte_in    (rx_data),
      .byte_idx   (byte_idx),
      .word_valid (word_valid),
      .word       (asm_word)
   );

   // The wait for the very first length byte is unbounded
   assign timing_on = (state_q == StLen && byte_idx != 2'd0) ||
                      state_q == StData || state_q == StChk;

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      csum_d   = csum_q;
      timer_d  = timer_q;
      mem_we_d = 1'b0;
      addr_d   = mem_addr;
      wdata_d  = mem_wdata;

      if (accept)         timer_d = '0;
      else if (timing_on) timer_d = timer_q + 1'b1;

      unique case (state_q)
         StLen: begin
            if (word_valid) begin
               if (asm_word > LEN_MAX) begin
                  state_d = StErr;
               end else if (asm_word == 32'd0) begin
                  state_d = StChk;
               end else begin
                  len_d   = asm_word[ADDR_W:0];
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (accept) csum_d = csum_q ^ rx_data;
            if (word_valid) begin
               mem_we_d = 1'b1;
               addr_d   = cnt_q[ADDR_W-1:0];
               wdata_d  = asm_word;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_d == len_q) state_d = StChk;
            end
         end
         StChk: begin
            if (accept) state_d = (rx_data == csum_q) ? StDone : StErr;
         end
         default: ;
      endcase

      if (timing_on && !accept && timer_q == TMO_LAST) state_d = StErr;

      asm_clear = (state_d == StDone) || (state_d == StErr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StLen;
         len_q      <= '0;
         cnt_q      <= '0;
         csum_q     <= '0;
         timer_q    <= '0;
         rx_ready   <= 1'b1;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         core_rst_n <= 1'b0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         csum_q     <= csum_d;
         timer_q    <= timer_d;
         rx_ready   <= !(state_d == StDone || state_d == StErr);
         mem_we     <= mem_we_d;
         mem_addr   <= addr_d;
         mem_wdata  <= wdata_d;
         // Core leaves reset one cycle after DONE is entered
         core_rst_n <= (state_q == StDone);
         load_done  <= (state_d == StDone);
         load_err   <= (state_d == StErr);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, length overflow, timeout, reset mid-load.
module tb_imem_loader;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned TMO    = 20;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = '0;
   logic              rx_ready, mem_we, core_rst_n, load_done, load_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];

   imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .core_rst_n (core_rst_n),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr.push_back(32'(mem_addr));
         wr_data.push_back(mem_wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      wr_addr.delete();
      wr_data.delete();
      rst_n = 1'b1;
   endtask

   // Leaves rx_valid high so consecutive calls stream back-to-back
   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[7:0]);
      send_byte(w[15:8]);
      send_byte(w[23:16]);
      send_byte(w[31:24]);
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_wr(input string tag, input int idx, input logic [31:0] a,
                           input logic [31:0] d);
      check({tag, "_addr"}, (wr_addr.size() > idx) ? wr_addr[idx] : 32'hxxxx_xxxx, a);
      check({tag, "_data"}, (wr_data.size() > idx) ? wr_data[idx] : 32'hxxxx_xxxx, d);
   endtask

   initial begin
      // Reset values
      do_reset();
      check("rst_rx_ready", 32'(rx_ready), 32'd1);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
      check("rst_done_err", {30'd0, load_done, load_err}, 32'd0);

      // 1: good two-word frame, checksum 0x71
      send_word(32'd2);
      send_word(32'h0050_0093);
      send_word(32'h00A0_0113);
      send_byte(8'h71);
      rx_valid = 1'b0;
      check("t1_load_done", 32'(load_done), 32'd1);
      check("t1_core_rst_early", 32'(core_rst_n), 32'd0);
      idle(1);
      check("t1_core_rst_n", 32'(core_rst_n), 32'd1);
      check("t1_rx_ready", 32'(rx_ready), 32'd0);
      check("t1_wr_count", 32'(wr_addr.size()), 32'd2);
      check_wr("t1_w0", 0, 32'd0, 32'h0050_0093);
      check_wr("t1_w1", 1, 32'd1, 32'h00A0_0113);
      send_byte(8'hAA);
      idle(2);
      check("t1_ignored_done", {30'd0, load_done, load_err}, 32'd2);
      check("t1_ignored_wr", 32'(wr_addr.size()), 32'd2);

      // 2: same frame, inverted checksum
      do_reset();
      send_word(32'd2);
      send_word(32'h0050_0093);
      send_word(32'h00A0_0113);
      send_byte(8'h8E);
      idle(2);
      check("t2_load_err", 32'(load_err), 32'd1);
      check("t2_load_done", 32'(load_done), 32'd0);
      check("t2_core_rst_n", 32'(core_rst_n), 32'd0);
      check("t2_rx_ready", 32'(rx_ready), 32'd0);

      // 3: length 0x401 exceeds 1024-word capacity
      do_reset();
      send_word(32'h0000_0401);
      rx_valid = 1'b0;
      check("t3_load_err", 32'(load_err), 32'd1);
      idle(3);
      check("t3_wr_count", 32'(wr_addr.size()), 32'd0);
      check("t3_rx_ready", 32'(rx_ready), 32'd0);

      // 4a: stall after 2nd data byte; error lands exactly on cycle TMO
      do_reset();
      send_word(32'd1);
      send_byte(8'hEF);
      send_byte(8'hBE);
      idle(TMO - 1);
      check("t4_no_err_yet", 32'(load_err), 32'd0);
      idle(1);
      check("t4_timeout_err", 32'(load_err), 32'd1);

      // 4b: stall TMO-2 cycles then finish; checksum EF^BE^AD^DE = 0x22
      do_reset();
      send_word(32'd1);
      send_byte(8'hEF);
      send_byte(8'hBE);
      idle(TMO - 2);
      send_byte(8'hAD);
      send_byte(8'hDE);
      send_byte(8'h22);
      idle(1);
      check("t4b_done_err", {30'd0, load_done, load_err}, 32'd2);
      check_wr("t4b_w0", 0, 32'd0, 32'hDEAD_BEEF);

      // 5: long idle before first byte, then empty image
      do_reset();
      idle(3 * TMO);
      check("t5_idle_no_err", 32'(load_err), 32'd0);
      check("t5_idle_ready", 32'(rx_ready), 32'd1);
      send_word(32'd0);
      send_byte(8'h00);
      idle(1);
      check("t5_done_err", {30'd0, load_done, load_err}, 32'd2);
      check("t5_wr_count", 32'(wr_addr.size()), 32'd0);

      // 6: reset after word 1 of 3, then full back-to-back resend; checksum 0xCC
      do_reset();
      send_word(32'd3);
      send_word(32'h1122_3344);
      idle(1);
      check("t6_partial_wr", 32'(wr_addr.size()), 32'd1);
      send_byte(8'h88);
      #2;
      rst_n = 1'b0;
      rx_valid = 1'b0;
      #1;
      check("t6_rst_rx_ready", 32'(rx_ready), 32'd1);
      check("t6_rst_we_addr", {21'd0, mem_we, mem_addr}, 32'd0);
      check("t6_rst_wdata", mem_wdata, 32'd0);
      check("t6_rst_flags", {29'd0, core_rst_n, load_done, load_err}, 32'd0);
      do_reset();
      send_word(32'd3);
      send_word(32'h1122_3344);
      send_word(32'h5566_7788);
      send_word(32'h99AA_BBCC);
      send_byte(8'hCC);
      idle(2);
      check("t6_done_err", {30'd0, load_done, load_err}, 32'd2);
      check("t6_core_rst_n", 32'(core_rst_n), 32'd1);
      check("t6_wr_count", 32'(wr_addr.size()), 32'd3);
      check_wr("t6_w0", 0, 32'd0, 32'h1122_3344);
      check_wr("t6_w1", 1, 32'd1, 32'h5566_7788);
      check_wr("t6_w2", 2, 32'd2, 32'h99AA_BBCC);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
